// File: rtl/uninasoc_pkg.sv
// Shared interrupt indices and gateway types for the PLIC path.
package uninasoc_pkg;

    localparam int unsigned PBUS_GPIOIN_INTERRUPT = 0;
    localparam int unsigned PBUS_TIM0_INTERRUPT   = 1;
    localparam int unsigned PBUS_TIM1_INTERRUPT   = 2;
    localparam int unsigned PBUS_UART_INTERRUPT   = 3;

    localparam int unsigned PLIC_NUM_LINES        = 32;
    localparam int unsigned PLIC_GPIOIN_INTERRUPT = 1;
    localparam int unsigned PLIC_TIM0_INTERRUPT   = 2;
    localparam int unsigned PLIC_TIM1_INTERRUPT   = 3;
    localparam int unsigned PLIC_UART_INTERRUPT   = 4;
    localparam int unsigned PLIC_HLS_INTERRUPT    = 5;
    localparam int unsigned PLIC_CDMA_INTERRUPT   = 6;

    // CDMA signals completion with short pulses, so its line is edge-triggered.
    localparam logic [31:0] PLIC_IRQ_EDGE_MASK = 32'h0000_0040;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_IN_SERVICE
    } irq_gw_state_t;

endpackage

// File: rtl/uninasoc_plic_irq_gateway_if.sv
// PLIC claim/complete command bundle seen by every gateway line.
interface uninasoc_plic_irq_gateway_if #(
    parameter int unsigned ID_W = 5
);
    logic            claim_valid;
    logic [ID_W-1:0] claim_id;
    logic            complete_valid;
    logic [ID_W-1:0] complete_id;

    modport master (output claim_valid, claim_id, complete_valid, complete_id);
    modport slave  (input  claim_valid, claim_id, complete_valid, complete_id);
endinterface

// File: rtl/uninasoc_irq_gateway_line.sv
// One PLIC line: request FSM, saturating pending-edge counter and sticky overflow flag.
module uninasoc_irq_gateway_line
    import uninasoc_pkg::*;
#(
    parameter int unsigned LINE_ID    = 1,
    parameter int unsigned ID_W       = 5,
    parameter bit          EDGE_MODE  = 1'b0,
    parameter int unsigned EDGE_CNT_W = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_level,
    input  logic                        i_edge,
    uninasoc_plic_irq_gateway_if.slave  cmd_if,
    output logic                        o_irq,
    output logic                        o_in_service,
    output logic                        o_overflow
);

    irq_gw_state_t         r_state;
    logic [EDGE_CNT_W-1:0] r_cnt;
    logic                  r_irq;
    logic                  r_in_service;
    logic                  r_overflow;

    logic w_claim_hit;
    logic w_complete_hit;
    logic w_req;
    logic w_inc;
    logic w_dec;

    // Commands only act when they match the current state; anything else is ignored.
    assign w_claim_hit    = cmd_if.claim_valid && (cmd_if.claim_id == ID_W'(LINE_ID))
                            && (r_state == GW_PENDING);
    assign w_complete_hit = cmd_if.complete_valid && (cmd_if.complete_id == ID_W'(LINE_ID))
                            && (r_state == GW_IN_SERVICE);
    assign w_req = EDGE_MODE ? (r_cnt != '0) : i_level;
    assign w_inc = EDGE_MODE && i_edge;
    assign w_dec = EDGE_MODE && w_claim_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= GW_IDLE;
            r_cnt        <= '0;
            r_irq        <= 1'b0;
            r_in_service <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            unique case (r_state)
                GW_IDLE: begin
                    if (w_req) begin
                        r_state <= GW_PENDING;
                        r_irq   <= 1'b1;
                    end
                end
                GW_PENDING: begin
                    if (w_claim_hit) begin
                        r_state      <= GW_IN_SERVICE;
                        r_irq        <= 1'b0;
                        r_in_service <= 1'b1;
                    end
                end
                GW_IN_SERVICE: begin
                    if (w_complete_hit) begin
                        r_state      <= GW_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= GW_IDLE;
                    r_irq        <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase

            // A new edge and a claim in the same cycle cancel out.
            if (w_inc && !w_dec) begin
                if (r_cnt == '1) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_irq        = r_irq;
    assign o_in_service = r_in_service;
    assign o_overflow   = r_overflow;

endmodule

// File: rtl/uninasoc_plic_irq_gateway.sv
// Maps interrupt sources onto PLIC lines, synchronises them and gates each through a per-line FSM.
module uninasoc_plic_irq_gateway
    import uninasoc_pkg::*;
#(
    parameter int unsigned          NUM_LINES   = PLIC_NUM_LINES,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [NUM_LINES-1:0] EDGE_MASK   = NUM_LINES'(PLIC_IRQ_EDGE_MASK),
    parameter int unsigned          EDGE_CNT_W  = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [3:0]                   pbus_irq_i,
    input  logic                         hls_irq_i,
    input  logic                         cdma_irq_i,
    input  logic                         claim_valid_i,
    input  logic [$clog2(NUM_LINES)-1:0] claim_id_i,
    input  logic                         complete_valid_i,
    input  logic [$clog2(NUM_LINES)-1:0] complete_id_i,
    output logic [NUM_LINES-1:0]         plic_irq_o,
    output logic [NUM_LINES-1:0]         in_service_o,
    output logic [NUM_LINES-1:0]         overflow_o
);

    localparam int unsigned ID_W = $clog2(NUM_LINES);

    logic [NUM_LINES-1:1] w_src;
    logic [NUM_LINES-1:1] w_s;
    logic [NUM_LINES-1:1] w_edge;
    logic [NUM_LINES-1:1] r_s_q;

    uninasoc_plic_irq_gateway_if #(.ID_W(ID_W)) u_cmd_if ();

    assign u_cmd_if.claim_valid    = claim_valid_i;
    assign u_cmd_if.claim_id       = claim_id_i;
    assign u_cmd_if.complete_valid = complete_valid_i;
    assign u_cmd_if.complete_id    = complete_id_i;

    always_comb begin
        w_src = '0;
        w_src[PLIC_GPIOIN_INTERRUPT] = pbus_irq_i[PBUS_GPIOIN_INTERRUPT];
        w_src[PLIC_TIM0_INTERRUPT]   = pbus_irq_i[PBUS_TIM0_INTERRUPT];
        w_src[PLIC_TIM1_INTERRUPT]   = pbus_irq_i[PBUS_TIM1_INTERRUPT];
        w_src[PLIC_UART_INTERRUPT]   = pbus_irq_i[PBUS_UART_INTERRUPT];
        w_src[PLIC_HLS_INTERRUPT]    = hls_irq_i;
        w_src[PLIC_CDMA_INTERRUPT]   = cdma_irq_i;
    end

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_s = w_src;
    end else begin : g_sync
        logic [NUM_LINES-1:1] r_sync [SYNC_STAGES];

        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= '0;
                end
            end else begin
                r_sync[0] <= w_src;
                for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_s_q <= '0;
        end else begin
            r_s_q <= w_s;
        end
    end

    assign w_edge = w_s & ~r_s_q;

    // Line 0 is reserved by the PLIC and never requests.
    assign plic_irq_o[0]   = 1'b0;
    assign in_service_o[0] = 1'b0;
    assign overflow_o[0]   = 1'b0;

    for (genvar l = 1; l < NUM_LINES; l++) begin : g_line
        uninasoc_irq_gateway_line #(
            .LINE_ID    (l),
            .ID_W       (ID_W),
            .EDGE_MODE  (EDGE_MASK[l]),
            .EDGE_CNT_W (EDGE_CNT_W)
        ) u_line (
            .i_clk        (clock_i),
            .i_rst        (reset_i),
            .i_level      (w_s[l]),
            .i_edge       (w_edge[l]),
            .cmd_if       (u_cmd_if),
            .o_irq        (plic_irq_o[l]),
            .o_in_service (in_service_o[l]),
            .o_overflow   (overflow_o[l])
        );
    end

endmodule

// File: tb/tb_uninasoc_plic_irq_gateway.sv
// Directed bench: default gateway plus a variant with 2-bit counters and edge mode on lines 2 and 6.
module tb_uninasoc_plic_irq_gateway;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pbus;
    logic        hls;
    logic        cdma;
    logic [31:0] irq, insvc, ovf;
    logic [31:0] irq2, insvc2, ovf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uninasoc_plic_irq_gateway_if #(.ID_W(5)) cmd ();

    uninasoc_plic_irq_gateway u_dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .pbus_irq_i       (pbus),
        .hls_irq_i        (hls),
        .cdma_irq_i       (cdma),
        .claim_valid_i    (cmd.claim_valid),
        .claim_id_i       (cmd.claim_id),
        .complete_valid_i (cmd.complete_valid),
        .complete_id_i    (cmd.complete_id),
        .plic_irq_o       (irq),
        .in_service_o     (insvc),
        .overflow_o       (ovf)
    );

    uninasoc_plic_irq_gateway #(
        .EDGE_MASK  (32'h0000_0044),
        .EDGE_CNT_W (2)
    ) u_dut_sat (
        .clock_i          (clk),
        .reset_i          (rst),
        .pbus_irq_i       (pbus),
        .hls_irq_i        (hls),
        .cdma_irq_i       (cdma),
        .claim_valid_i    (cmd.claim_valid),
        .claim_id_i       (cmd.claim_id),
        .complete_valid_i (cmd.complete_valid),
        .complete_id_i    (cmd.complete_id),
        .plic_irq_o       (irq2),
        .in_service_o     (insvc2),
        .overflow_o       (ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic claim(input logic [4:0] id);
        cmd.claim_valid = 1'b1;
        cmd.claim_id    = id;
        tick();
        cmd.claim_valid = 1'b0;
        cmd.claim_id    = '0;
    endtask

    task automatic complete(input logic [4:0] id);
        cmd.complete_valid = 1'b1;
        cmd.complete_id    = id;
        tick();
        cmd.complete_valid = 1'b0;
        cmd.complete_id    = '0;
    endtask

    task automatic pulse_cdma();
        cdma = 1'b1;
        tick();
        cdma = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; pbus = '0; hls = 1'b0; cdma = 1'b0;
        cmd.claim_valid = 1'b0; cmd.claim_id = '0;
        cmd.complete_valid = 1'b0; cmd.complete_id = '0;
        ticks(2);
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL reset_irq: got %h want %h", irq, 32'h0); end
        checks++; if (insvc !== 32'h0) begin errors++; $display("FAIL reset_insvc: got %h want %h", insvc, 32'h0); end
        checks++; if (ovf !== 32'h0) begin errors++; $display("FAIL reset_ovf: got %h want %h", ovf, 32'h0); end
        rst = 1'b0;
        tick();
        checks++; if (irq2 !== 32'h0) begin errors++; $display("FAIL reset_release: got %h want %h", irq2, 32'h0); end
    endtask

    task automatic test_level_uart();
        pbus = 4'b1000;
        tick();
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL uart_lat1: got %h want %h", irq, 32'h0); end
        tick();
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL uart_lat2: got %h want %h", irq, 32'h0); end
        tick();
        checks++; if (irq !== 32'h10) begin errors++; $display("FAIL uart_lat3: got %h want %h", irq, 32'h10); end
        claim(5'd4);
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL uart_claim_irq: got %h want %h", irq, 32'h0); end
        checks++; if (insvc !== 32'h10) begin errors++; $display("FAIL uart_claim_insvc: got %h want %h", insvc, 32'h10); end
        ticks(2);
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL uart_held_in_service: got %h want %h", irq, 32'h0); end
        complete(5'd4);
        checks++; if ({irq, insvc} !== 64'h0) begin errors++; $display("FAIL uart_idle_m1: got %h want %h", {irq, insvc}, 64'h0); end
        tick();
        checks++; if (irq !== 32'h10) begin errors++; $display("FAIL uart_reraise_m2: got %h want %h", irq, 32'h10); end
        pbus = 4'b0000;
        ticks(3);
        checks++; if (irq !== 32'h10) begin errors++; $display("FAIL uart_hold_pending: got %h want %h", irq, 32'h10); end
        claim(5'd4);
        complete(5'd4);
        tick();
        checks++; if ({irq, insvc} !== 64'h0) begin errors++; $display("FAIL uart_quiet: got %h want %h", {irq, insvc}, 64'h0); end
    endtask

    task automatic test_edge_cdma();
        logic [31:0] exp;
        pulse_cdma(); pulse_cdma(); pulse_cdma();
        ticks(4);
        checks++; if (irq !== 32'h40) begin errors++; $display("FAIL cdma_pending: got %h want %h", irq, 32'h40); end
        for (int unsigned r = 0; r < 3; r++) begin
            claim(5'd6);
            checks++; if ({irq, insvc} !== {32'h0, 32'h40}) begin errors++; $display("FAIL cdma_claim%0d: got %h want %h", r, {irq, insvc}, {32'h0, 32'h40}); end
            complete(5'd6);
            tick();
            exp = (r < 2) ? 32'h40 : 32'h0;
            checks++; if (irq !== exp) begin errors++; $display("FAIL cdma_round%0d: got %h want %h", r, irq, exp); end
        end
        ticks(3);
        checks++; if ({irq, insvc} !== 64'h0) begin errors++; $display("FAIL cdma_stays_idle: got %h want %h", {irq, insvc}, 64'h0); end
        checks++; if ({ovf, ovf2} !== 64'h0) begin errors++; $display("FAIL cdma_no_overflow: got %h want %h", {ovf, ovf2}, 64'h0); end
    endtask

    task automatic test_saturation();
        for (int unsigned p = 0; p < 5; p++) pulse_cdma();
        ticks(4);
        checks++; if (ovf2 !== 32'h40) begin errors++; $display("FAIL sat_overflow: got %h want %h", ovf2, 32'h40); end
        checks++; if (ovf !== 32'h0) begin errors++; $display("FAIL sat_wide_no_overflow: got %h want %h", ovf, 32'h0); end
        checks++; if ({irq, irq2} !== {32'h40, 32'h40}) begin errors++; $display("FAIL sat_pending: got %h want %h", {irq, irq2}, {32'h40, 32'h40}); end
        for (int unsigned r = 0; r < 3; r++) begin
            claim(5'd6);
            complete(5'd6);
            tick();
        end
        checks++; if (irq2 !== 32'h0) begin errors++; $display("FAIL sat_cnt3_drained: got %h want %h", irq2, 32'h0); end
        checks++; if (irq !== 32'h40) begin errors++; $display("FAIL sat_wide_cnt_left: got %h want %h", irq, 32'h40); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ovf2 !== 32'h0) begin errors++; $display("FAIL sat_reset_ovf: got %h want %h", ovf2, 32'h0); end
        checks++; if ({irq, irq2} !== 64'h0) begin errors++; $display("FAIL sat_reset_irq: got %h want %h", {irq, irq2}, 64'h0); end
    endtask

    task automatic test_illegal();
        pbus = 4'b1000;
        ticks(4);
        checks++; if (irq !== 32'h10) begin errors++; $display("FAIL ill_setup: got %h want %h", irq, 32'h10); end
        claim(5'd0);
        checks++; if ({irq, insvc} !== {32'h10, 32'h0}) begin errors++; $display("FAIL ill_claim_id0: got %h want %h", {irq, insvc}, {32'h10, 32'h0}); end
        claim(5'd2);
        checks++; if ({irq, insvc} !== {32'h10, 32'h0}) begin errors++; $display("FAIL ill_claim_idle: got %h want %h", {irq, insvc}, {32'h10, 32'h0}); end
        claim(5'd31);
        checks++; if ({irq, insvc} !== {32'h10, 32'h0}) begin errors++; $display("FAIL ill_claim_tied: got %h want %h", {irq, insvc}, {32'h10, 32'h0}); end
        complete(5'd4);
        checks++; if ({irq, insvc} !== {32'h10, 32'h0}) begin errors++; $display("FAIL ill_complete_pending: got %h want %h", {irq, insvc}, {32'h10, 32'h0}); end
        claim(5'd4);
        claim(5'd4);
        checks++; if ({irq, insvc} !== {32'h0, 32'h10}) begin errors++; $display("FAIL ill_claim_in_service: got %h want %h", {irq, insvc}, {32'h0, 32'h10}); end
        complete(5'd2);
        checks++; if ({irq, insvc} !== {32'h0, 32'h10}) begin errors++; $display("FAIL ill_complete_idle: got %h want %h", {irq, insvc}, {32'h0, 32'h10}); end
        pbus = 4'b0000;
        ticks(3);
        complete(5'd4);
        tick();
        checks++; if ({irq, insvc} !== 64'h0) begin errors++; $display("FAIL ill_cleanup: got %h want %h", {irq, insvc}, 64'h0); end
    endtask

    task automatic test_concurrency();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pbus = 4'b0110;
        tick();
        pbus = 4'b0100;
        ticks(5);
        checks++; if (irq2 !== 32'h0C) begin errors++; $display("FAIL conc_setup: got %h want %h", irq2, 32'h0C); end
        // Second TIM0 pulse timed so its edge event coincides with the claim of line 2.
        pbus = 4'b0110;
        tick();
        pbus = 4'b0100;
        tick();
        claim(5'd2);
        checks++; if ({irq2, insvc2} !== {32'h08, 32'h04}) begin errors++; $display("FAIL conc_claim_edge: got %h want %h", {irq2, insvc2}, {32'h08, 32'h04}); end
        cmd.claim_valid = 1'b1; cmd.claim_id = 5'd3;
        cmd.complete_valid = 1'b1; cmd.complete_id = 5'd2;
        tick();
        cmd.claim_valid = 1'b0; cmd.claim_id = '0;
        cmd.complete_valid = 1'b0; cmd.complete_id = '0;
        checks++; if ({irq2, insvc2} !== {32'h0, 32'h08}) begin errors++; $display("FAIL conc_claim_and_complete: got %h want %h", {irq2, insvc2}, {32'h0, 32'h08}); end
        tick();
        checks++; if ({irq2, insvc2} !== {32'h04, 32'h08}) begin errors++; $display("FAIL conc_cnt_kept: got %h want %h", {irq2, insvc2}, {32'h04, 32'h08}); end
        checks++; if ({irq, insvc} !== {32'h0, 32'h08}) begin errors++; $display("FAIL conc_level_line2: got %h want %h", {irq, insvc}, {32'h0, 32'h08}); end
    endtask

    task automatic test_reset_mid();
        pbus = 4'b1100;
        ticks(4);
        claim(5'd4);
        pbus = 4'b1110;
        ticks(4);
        checks++; if ({irq, insvc} !== {32'h04, 32'h18}) begin errors++; $display("FAIL mid_setup: got %h want %h", {irq, insvc}, {32'h04, 32'h18}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({irq, insvc, ovf} !== 96'h0) begin errors++; $display("FAIL mid_reset_main: got %h want %h", {irq, insvc, ovf}, 96'h0); end
        checks++; if ({irq2, insvc2, ovf2} !== 96'h0) begin errors++; $display("FAIL mid_reset_sat: got %h want %h", {irq2, insvc2, ovf2}, 96'h0); end
        ticks(2);
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL mid_lat2: got %h want %h", irq, 32'h0); end
        tick();
        checks++; if (irq !== 32'h1C) begin errors++; $display("FAIL mid_lat3: got %h want %h", irq, 32'h1C); end
        checks++; if (irq2 !== 32'h18) begin errors++; $display("FAIL mid_edge_lat3: got %h want %h", irq2, 32'h18); end
        tick();
        checks++; if (irq2 !== 32'h1C) begin errors++; $display("FAIL mid_edge_lat4: got %h want %h", irq2, 32'h1C); end
    endtask

    initial begin
        test_reset();
        test_level_uart();
        test_edge_cdma();
        test_saturation();
        test_illegal();
        test_concurrency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
